// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round constants, initial hash value,
// controller state encoding and the FIPS 180-4 logical functions.
package sha256_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Initial chaining value H0..H7, H0 in the top word.
  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  // Round constants K[0..63].
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_iter_ctrl_if.sv
// Block-in / digest-out bus of the iterative SHA-256 controller.
// Handshake rule for both channels: a transfer happens at a rising edge where
// valid && ready are both high; the source holds valid and its payload stable
// until that edge, and valid never depends combinationally on ready.
interface sha256_iter_ctrl_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         hash_valid;
  logic         hash_ready;
  logic [255:0] hash;

  // Hashing core side.
  modport slave (
    input  blk_valid, blk_data, blk_first, blk_last, hash_ready,
    output blk_ready, hash_valid, hash
  );

  // Block producer / digest consumer side.
  modport master (
    output blk_valid, blk_data, blk_first, blk_last, hash_ready,
    input  blk_ready, hash_valid, hash
  );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: next {a..h} from {a..h}, K[t], Wt.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] i_v,
  input  logic [31:0]  i_k,
  input  logic [31:0]  i_w,
  output logic [255:0] o_v
);
  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_t1, w_t2;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = i_v;
  assign w_t1 = w_h + big_sigma1(w_e) + ch(w_e, w_f, w_g) + i_k + i_w;
  assign w_t2 = big_sigma0(w_a) + maj(w_a, w_b, w_c);
  assign o_v  = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};
endmodule

// File: rtl/sha256_iter_ctrl.sv
// Iterative SHA-256 engine: one round per clock over a rolling 16-word
// message schedule, one cycle of chaining accumulation, then digest hand-off.
module sha256_iter_ctrl
  import sha256_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  sha256_iter_ctrl_if.slave  bus,
  output logic               busy,
  output logic [5:0]         round_idx,
  output state_t             o_dbg_state
);
  state_t       r_state;
  logic [255:0] r_h;          // chaining value H0..H7
  logic [255:0] r_v;          // working variables a..h
  logic [31:0]  r_w [16];     // schedule window, r_w[0] is Wt
  logic [5:0]   r_round_idx;
  logic         r_last;
  logic         r_hash_valid;

  logic [255:0] w_v_next;
  logic [31:0]  w_w_new;

  sha256_round u_round (
    .i_v (r_v),
    .i_k (K[r_round_idx]),
    .i_w (r_w[0]),
    .o_v (w_v_next)
  );

  // Schedule word sixteen positions ahead of the current one.
  assign w_w_new = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];

  assign bus.blk_ready  = (r_state == ST_IDLE);
  assign bus.hash_valid = r_hash_valid;
  assign bus.hash       = r_h;
  assign busy           = (r_state == ST_ROUND) || (r_state == ST_FINAL);
  assign round_idx      = r_round_idx;
  assign o_dbg_state    = r_state;

  // Controller FSM plus every datapath register it sequences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_h          <= IV;
      r_v          <= '0;
      r_round_idx  <= '0;
      r_last       <= 1'b0;
      r_hash_valid <= 1'b0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.blk_valid) begin
            // A new message restarts from IV; otherwise continue from H.
            r_v <= bus.blk_first ? IV : r_h;
            if (bus.blk_first) r_h <= IV;
            for (int i = 0; i < 16; i++) r_w[i] <= bus.blk_data[511 - 32*i -: 32];
            r_last      <= bus.blk_last;
            r_round_idx <= '0;
            r_state     <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          r_v <= w_v_next;
          for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
          r_w[15]     <= w_w_new;
          // Six-bit counter wraps 63 -> 0 on the last round.
          r_round_idx <= r_round_idx + 6'd1;
          if (r_round_idx == 6'd63) r_state <= ST_FINAL;
        end
        ST_FINAL: begin
          for (int i = 0; i < 8; i++)
            r_h[255 - 32*i -: 32] <= r_h[255 - 32*i -: 32] + r_v[255 - 32*i -: 32];
          r_state <= r_last ? ST_DONE : ST_IDLE;
        end
        ST_DONE: begin
          // First DONE cycle raises hash_valid; it stays until consumed.
          if (!r_hash_valid) begin
            r_hash_valid <= 1'b1;
          end else if (bus.hash_ready) begin
            r_hash_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule
